// File: rtl/udma_apb_cfg_bridge.sv
// APB3 slave that turns each transfer into one uDMA cfg-bus transaction.
// Peripheral index in paddr[11:7], word address in paddr[6:2].
module udma_apb_cfg_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic [N_PERIPHS-1:0]      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [N_PERIPHS*32-1:0]   cfg_data_i,
  input  logic [N_PERIPHS-1:0]      cfg_ready_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [5:0] NP    = 6'(N_PERIPHS);
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rwn_q, rwn_d;

  logic [N_PERIPHS-1:0] hit;
  logic                 sel_ready;
  logic [31:0]          sel_data;
  logic                 setup;
  logic                 oor;
  logic                 in_req;
  logic                 unused_paddr;

  assign unused_paddr = ^paddr_i;

  // AND-OR mux keeps unknowns on unselected slaves out of the result
  always_comb begin
    hit       = '0;
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_PERIPHS; i++) begin
      hit[i]    = (idx_q == 5'(i));
      sel_ready = sel_ready | (hit[i] & cfg_ready_i[i]);
      sel_data  = sel_data | ({32{hit[i]}} & cfg_data_i[i*32 +: 32]);
    end
  end

  assign setup  = psel_i & ~penable_i;
  assign oor    = {1'b0, paddr_i[11:7]} >= NP;
  assign in_req = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rwn_d   = rwn_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d   = paddr_i[11:7];
          waddr_d = paddr_i[6:2];
          wdata_d = pwdata_i;
          rwn_d   = ~pwrite_i;
          cnt_d   = '0;
          state_d = oor ? ERR : REQ;
        end
      end
      REQ: begin
        if (sel_ready) begin
          rdata_d = rwn_q ? sel_data : '0;
          state_d = DONE;
        end else if (cnt_q == TLAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE, ERR: begin
        // completes on access phase, or drops if master deselects
        if (!setup) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rwn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rwn_q   <= rwn_d;
    end
  end

  assign cfg_valid_o = in_req ? hit : '0;
  assign cfg_addr_o  = in_req ? waddr_q : '0;
  assign cfg_rwn_o   = in_req & rwn_q;
  assign cfg_data_o  = (in_req & ~rwn_q) ? wdata_q : '0;

  assign pready_o  = (state_q == DONE) | (state_q == ERR);
  assign pslverr_o = (state_q == ERR);
  assign prdata_o  = (state_q == DONE) ? rdata_q : '0;

endmodule

// File: doc/udma_apb_cfg_bridge.md
Name: udma_apb_cfg_bridge

Overview:
- APB3 slave to uDMA cfg-bus initiator. This is the block that drives the cfg_data/cfg_addr/cfg_valid/cfg_rwn bus into udma_ctrl and the per-peripheral register files, and collects cfg_data/cfg_ready back.
- Decodes one APB window into N_PERIPHS sub-windows of 32 word registers each.
- Runs one cfg transaction per APB transfer and stretches the APB access with pready_o.
- Returns pslverr_o on an out-of-range peripheral index or when the peripheral never responds (timeout).

Parameters:
- APB_ADDR_WIDTH, 12: paddr_i width. paddr_i[11:7] is the peripheral index, paddr_i[6:2] is the cfg word address, paddr_i[1:0] is ignored.
- N_PERIPHS, 16: number of cfg slaves, 1..32.
- TIMEOUT_CYCLES, 255: maximum number of REQ cycles without cfg_ready before an error, 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- paddr_i  in  APB_ADDR_WIDTH  APB address
- pwdata_i  in  32  APB write data
- pwrite_i  in  1  APB write=1, read=0
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- cfg_data_o  out  32  write data to slaves
- cfg_addr_o  out  5  register word address
- cfg_valid_o  out  N_PERIPHS  one-hot request strobe
- cfg_rwn_o  out  1  1=read, 0=write
- cfg_data_i  in  N_PERIPHS x 32  per-slave read data (packed)
- cfg_ready_i  in  N_PERIPHS  per-slave ready

Behaviour:
- Reset, asynchronous on rst_i high:
  - state IDLE, timeout counter 0, captured registers 0.
  - All outputs 0: prdata_o, pready_o, pslverr_o, cfg_data_o, cfg_addr_o, cfg_valid_o, cfg_rwn_o.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - On psel_i=1 & penable_i=0 (setup phase), capture idx=paddr_i[11:7], waddr=paddr_i[6:2], wdata=pwdata_i, rwn=~pwrite_i, and clear the counter.
  - idx >= N_PERIPHS -> ERR. Otherwise -> REQ.
- REQ:
  - Drive cfg_valid_o[idx]=1 (all other bits 0), cfg_addr_o=waddr, cfg_rwn_o=rwn, cfg_data_o=wdata if write, else 0.
  - cfg_ready_i[idx]=1 -> DONE. On a read, capture cfg_data_i[idx] into rdata; on a write, rdata=0.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no ready -> ERR.
- DONE: pready_o=1, pslverr_o=0, prdata_o=rdata.
- ERR: pready_o=1, pslverr_o=1, prdata_o=0.
- Leaving DONE/ERR:
  - psel_i=1 & penable_i=1 -> IDLE (transfer completes this cycle).
  - psel_i=0 (master abandoned the transfer) -> IDLE, response dropped.
- Outside REQ: cfg_valid_o, cfg_addr_o, cfg_data_o and cfg_rwn_o are all 0. The bus is gated exactly as the slaves gate their own decode.
- Outside DONE/ERR: pready_o=0, pslverr_o=0, prdata_o=0.
- Latency with an always-ready slave:
  - T0 setup edge captures the request.
  - T1: REQ, cfg_valid_o high, ready sampled.
  - T2: DONE, pready_o high.
  - Each APB transfer is exactly 3 cycles (1 wait state). Each extra cycle of cfg_ready_i low adds 1 cycle.
- REQ stability: the request is held unchanged from entry to exit, whatever psel_i/penable_i/paddr_i do meanwhile (abandoning the APB transfer does not abort the cfg transaction).
- Back-to-back: a new setup phase is accepted only in IDLE. The earliest next cfg_valid_o is 2 cycles after pready_o.
- cfg_ready_i bits other than [idx] are ignored. X on unselected cfg_data_i must not propagate.
- Counter width is 8 bits and never wraps: the ERR transition occurs first.
- Reset mid-REQ: cfg_valid_o drops immediately (asynchronous). No response is issued after reset release.

Test Plan:
- Write 0x0000_00A5 to paddr 0x184 (idx 3, addr 1); slave ready tied 1 -> T1 cfg_valid_o=0x0008, cfg_addr_o=1, cfg_rwn_o=0, cfg_data_o=0xA5; T2 pready_o=1, pslverr_o=0; cfg_valid_o=0 from T2.
- Read paddr 0x05C (idx 0, addr 0x17), slave 0 returns 0x1234_5678 with ready low for 3 REQ cycles -> cfg_valid_o=0x0001 held 4 cycles; pready_o 1 cycle later with prdata_o=0x1234_5678.
- Access paddr 0x800 (idx 16) with N_PERIPHS=16 -> no cfg_valid_o pulse; next cycle pready_o=1, pslverr_o=1, prdata_o=0.
- Read idx 2 with cfg_ready_i[2] stuck 0 and TIMEOUT_CYCLES=8 -> cfg_valid_o[2] high exactly 8 cycles, then pready_o=1, pslverr_o=1; cfg_ready_i[5]=1 throughout has no effect.
- Assert rst_i while in REQ for idx 4 -> cfg_valid_o=0 and state IDLE the same cycle; after release a fresh write to idx 1 completes normally in 3 cycles.
- Two back-to-back writes (idx 0 then idx 1) -> two distinct one-cycle cfg_valid_o pulses, 0x0001 then 0x0002, in order, with at least 2 cycles between them.
